mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port unified program/data RAM between three requesters:
//   debug/loader (program load, tohost poll, signature readout), CPU data
//   port (MEM stage) and CPU instruction fetch (IF stage). Sits between the
//   core and the RAM. Fixed priority dbg > data > fetch, plus a fetch
//   anti-starvation boost and a lock mode that parks the core for the loader.
// PARAMETERS
//   AW         16  byte-address width; RAM word index = addr[AW-1:2]
//   MAX_STALL  4   consecutive denied fetch cycles before fetch outranks data
//   CW         16  width of the fetch-stall performance counter (saturating)
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst           in   1      synchronous reset, active-high
//   dbg_lock      in   1      request exclusive RAM ownership for debug/loader
//   dbg_req/dbg_we in  1/1    debug access request / write enable
//   dbg_be        in   4      debug byte enables (writes only)
//   dbg_addr      in   AW     debug byte address
//   dbg_wdata     in   32     debug write data
//   dbg_gnt       out  1      debug access accepted this cycle
//   dbg_rvalid    out  1      debug read data valid
//   dbg_rdata     out  32     debug read data
//   d_req/d_we    in   1/1    data-port request / write enable
//   d_be          in   4      data-port byte enables
//   d_addr        in   AW     data-port byte address
//   d_wdata       in   32     data-port write data
//   d_gnt, d_rvalid out 1/1   data grant / read data valid
//   d_rdata       out  32     data-port read data
//   i_req         in   1      fetch request (read only)
//   i_addr        in   AW     fetch byte address
//   i_gnt, i_rvalid out 1/1   fetch grant / instruction valid
//   i_rdata       out  32     fetched instruction
//   cpu_hold      out  1      high while in LOCKED; core must freeze
//   mem_en        out  1      RAM access enable
//   mem_we        out  4      RAM byte write enables
//   mem_addr      out  AW-2   RAM word index
//   mem_wdata     out  32     RAM write data
//   mem_rdata     in   32     RAM read data, valid 1 cycle after read access
//   fetch_stalls  out  CW     count of cycles with i_req && !i_gnt
// BEHAVIOUR
//   - Reset: state RUN; all gnt/rvalid 0, mem_en 0, mem_we 0, cpu_hold 0,
//     fetch_stalls 0, starvation counter 0, pending-read owner cleared.
//     Reset mid-read drops that read's rvalid. Grants forced 0 while rst high.
//   - Grant is combinational, same cycle as req; exactly one gnt max per
//     cycle; mem_en = |gnt; mem_we = be of granted writer, else 0.
//   - FSM: RUN -> LOCKED when dbg_lock=1 at posedge; LOCKED -> RUN when
//     dbg_lock=0 at posedge. cpu_hold = (state==LOCKED), registered.
//   - RUN priority: dbg > data > fetch; if starve_cnt==MAX_STALL then
//     dbg > fetch > data. LOCKED: only dbg granted; d/i never granted.
//   - starve_cnt: +1 when i_req && !i_gnt (saturates at MAX_STALL); cleared
//     on i_gnt or !i_req. Not advanced in LOCKED.
//   - Read latency 1: granted read at cycle N -> owner's rvalid=1 and
//     rdata=mem_rdata at N+1 (owner registered). Writes never raise rvalid.
//     Non-owner rdata outputs hold 0.
//   - A read granted in the cycle dbg_lock rises still returns its rvalid.
//   - addr[1:0] ignored; misalignment is the requester's concern.
//   - fetch_stalls saturates at all-ones; counts in both states.
// TESTING
//   1 rst=1 with all reqs high -> all gnt 0, mem_en 0; after release
//     dbg_gnt=1 only, fetch_stalls increments from 0.
//   2 d_req=1 d_we=0 d_addr=0x10, i_req=1 same cycle -> d_gnt=1, mem_addr=4;
//     next cycle d_rvalid=1 d_rdata=RAM[4], i_rvalid=0.
//   3 d_req held high 5 cycles with i_req high (MAX_STALL=4) -> i denied 4
//     cycles, granted cycle 5; fetch_stalls=4; starve_cnt back to 0.
//   4 dbg write dbg_be=4'b0011 addr 0x5000 wdata 0x1 -> mem_we=0011,
//     mem_addr=0x1400, no dbg_rvalid.
//   5 dbg_lock=1 while d read in flight -> d_rvalid still arrives next cycle;
//     then cpu_hold=1, d_gnt/i_gnt 0; dbg reads 0x5000..0x5008 return words.
//   6 Pulse rst in cycle after granted read -> no rvalid on any port.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port program/data RAM between three requesters:
//   debug/loader, CPU data port (MEM stage) and CPU instruction fetch
//   (IF stage). Fixed priority dbg > data > fetch. A fetch that has been
//   denied MAX_STALL consecutive cycles is promoted above data. A lock mode
//   parks the core (cpu_hold) so the loader owns the RAM exclusively.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     dbg_lock                 request exclusive RAM ownership for debug
//     dbg_req/we/be/addr/wdata debug access request (read or byte write)
//     dbg_gnt/rvalid/rdata     debug grant, read data valid, read data
//     d_req/we/be/addr/wdata   CPU data-port request
//     d_gnt/rvalid/rdata       CPU data-port grant, read response
//     i_req/addr               CPU fetch request (read only)
//     i_gnt/rvalid/rdata       CPU fetch grant, instruction response
//     cpu_hold                 high while LOCKED; the core must freeze
//     mem_en/we/addr/wdata     RAM access (addr is the word index)
//     mem_rdata                RAM read data, one cycle after a read
//     fetch_stalls             saturating count of cycles with i_req && !i_gnt
//
//   Handshake: a requester holds req (and its address/data) until it sees
//   gnt in the same cycle; gnt is combinational from req and means the
//   access happens this cycle. A granted read answers with a one-cycle
//   rvalid pulse and rdata exactly one cycle later; writes never answer.
//   The debug FSM state is visible directly on cpu_hold (1 = LOCKED).
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int MAX_STALL = 4,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dbg_lock,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [3:0]    dbg_be,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          cpu_hold,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [CW-1:0] fetch_stalls
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);

    typedef enum logic {ST_RUN, ST_LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_D, OWN_I} owner_t;

    state_t        state, state_next;
    owner_t        rd_owner, rd_owner_next;
    logic [SW-1:0] starve_cnt;
    logic          fetch_boost;

    // Byte lanes within a word are the requester's business.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{dbg_addr[1:0], d_addr[1:0], i_addr[1:0]};

    assign fetch_boost = (starve_cnt == STALL_LIM);
    assign cpu_hold    = (state == ST_LOCKED);

    // Lock follows dbg_lock one cycle later in both directions.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (dbg_lock)  state_next = ST_LOCKED;
            ST_LOCKED: if (!dbg_lock) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // Grant selection. Debug wins in both states; the CPU ports only
    // compete while RUN, with fetch promoted over data once starved.
    always_comb begin
        dbg_gnt = 1'b0;
        d_gnt   = 1'b0;
        i_gnt   = 1'b0;
        if (!rst) begin
            if (dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (state == ST_RUN) begin
                if (fetch_boost && i_req) i_gnt = 1'b1;
                else if (d_req)           d_gnt = 1'b1;
                else if (i_req)           i_gnt = 1'b1;
            end
        end
    end

    // RAM port mux driven by the single granted requester.
    always_comb begin
        mem_we        = 4'b0000;
        mem_addr      = '0;
        mem_wdata     = '0;
        rd_owner_next = OWN_NONE;
        if (dbg_gnt) begin
            mem_addr  = dbg_addr[AW-1:2];
            mem_wdata = dbg_wdata;
            if (dbg_we) mem_we = dbg_be;
            else        rd_owner_next = OWN_DBG;
        end else if (d_gnt) begin
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
            if (d_we) mem_we = d_be;
            else      rd_owner_next = OWN_D;
        end else if (i_gnt) begin
            mem_addr      = i_addr[AW-1:2];
            rd_owner_next = OWN_I;
        end
    end

    assign mem_en = dbg_gnt | d_gnt | i_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            rd_owner     <= OWN_NONE;
            starve_cnt   <= '0;
            fetch_stalls <= '0;
        end else begin
            state    <= state_next;
            rd_owner <= rd_owner_next;
            // Starvation only accrues while the core is running.
            if (!i_req || i_gnt)
                starve_cnt <= '0;
            else if (state == ST_RUN && starve_cnt != STALL_LIM)
                starve_cnt <= starve_cnt + 1'b1;
            if (i_req && !i_gnt && fetch_stalls != '1)
                fetch_stalls <= fetch_stalls + 1'b1;
        end
    end

    // Responses are gated by rst so a reset landing in the response cycle
    // swallows the outstanding read.
    assign dbg_rvalid = !rst && (rd_owner == OWN_DBG);
    assign d_rvalid   = !rst && (rd_owner == OWN_D);
    assign i_rvalid   = !rst && (rd_owner == OWN_I);
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;
    assign d_rdata    = d_rvalid   ? mem_rdata : 32'h0;
    assign i_rdata    = i_rvalid   ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW        = 16;
    localparam int MAX_STALL = 4;
    localparam int CW        = 16;
    localparam int NWORDS    = 1 << (AW - 2);

    logic          clk;
    logic          rst;
    logic          dbg_lock, dbg_req, dbg_we;
    logic [3:0]    dbg_be;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [31:0]   i_rdata;
    logic          cpu_hold, mem_en;
    logic [3:0]    mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] fetch_stalls;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram     [0:NWORDS-1];
    logic [31:0] ref_mem [0:NWORDS-1];
    logic [31:0] exp_q[$];

    mem_port_arbiter #(.AW(AW), .MAX_STALL(MAX_STALL), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .dbg_lock(dbg_lock), .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_be(dbg_be), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .cpu_hold(cpu_hold), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_stalls(fetch_stalls)
    );

    // ---------------- clock / RAM environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dbg_lock = 0; dbg_req = 0; dbg_we = 0; dbg_be = 0; dbg_addr = 0; dbg_wdata = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        i_req = 0; i_addr = 0;
    endtask

    task automatic do_reset();
        next_cycle();
        drive_idle();
        rst = 1;
        next_cycle();
        rst = 0;
        exp_q.delete();
    endtask

    task automatic ref_write(input logic [AW-3:0] w, input logic [3:0] be, input logic [31:0] data);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        next_cycle();
        rst = 1; dbg_req = 1; d_req = 1; i_req = 1;
        @(negedge clk);
        checks++;
        if ({dbg_gnt, d_gnt, i_gnt, mem_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=0000", {dbg_gnt, d_gnt, i_gnt, mem_en});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cpu_hold, dbg_rvalid, d_rvalid, i_rvalid} !== 4'b0000 || fetch_stalls !== 0) begin
            failures++; $display("FAIL reset_state got hold/rv=%b stalls=%0d exp 0", {cpu_hold, dbg_rvalid, d_rvalid, i_rvalid}, fetch_stalls);
        end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({dbg_gnt, d_gnt, i_gnt} !== 3'b100 || fetch_stalls !== 0) begin
            failures++; $display("FAIL release_gnt got=%b stalls=%0d exp=100 stalls=0", {dbg_gnt, d_gnt, i_gnt}, fetch_stalls);
        end
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (fetch_stalls !== CW'(k)) begin
                failures++; $display("FAIL stall_count got=%0d exp=%0d", fetch_stalls, k);
            end
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_data_read();
        do_reset();
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 16'h0010; i_req = 1; i_addr = 16'h0080;
        @(negedge clk);
        checks++;
        if ({d_gnt, i_gnt, mem_en} !== 3'b101 || mem_addr !== 14'd4 || mem_we !== 4'b0) begin
            failures++; $display("FAIL data_read_gnt got d/i/en=%b addr=%0h we=%b exp 101 addr=4 we=0", {d_gnt, i_gnt, mem_en}, mem_addr, mem_we);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[4] || i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            failures++; $display("FAIL data_read_resp got rv=%b data=%h i_rv=%b exp rv=1 data=%h i_rv=0", d_rvalid, d_rdata, i_rvalid, ref_mem[4]);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            d_req = 1; d_we = 0; d_addr = 16'h0040; i_req = 1; i_addr = 16'h0100;
            @(negedge clk);
            checks++;
            if (i_gnt !== (k == 5) || d_gnt !== (k != 5)) begin
                failures++; $display("FAIL starve_cycle%0d got d=%b i=%b exp i=%b", k, d_gnt, i_gnt, k == 5);
            end
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (fetch_stalls !== 4 || i_rvalid !== 1'b1 || i_rdata !== ref_mem[64]) begin
            failures++; $display("FAIL starve_after got stalls=%0d rv=%b data=%h exp 4 1 %h", fetch_stalls, i_rvalid, i_rdata, ref_mem[64]);
        end
        next_cycle();
        d_req = 1; i_req = 1;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            failures++; $display("FAIL starve_cleared got d=%b i=%b exp d=1 i=0", d_gnt, i_gnt);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_dbg_write();
        do_reset();
        next_cycle();
        dbg_req = 1; dbg_we = 1; dbg_be = 4'b0011; dbg_addr = 16'h5000; dbg_wdata = 32'h1;
        @(negedge clk);
        checks++;
        if (dbg_gnt !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 14'h1400 || mem_wdata !== 32'h1) begin
            failures++; $display("FAIL dbg_write got gnt=%b we=%b addr=%h wd=%h exp 1 0011 1400 1", dbg_gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_write(14'h1400, 4'b0011, 32'h1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (dbg_rvalid !== 1'b0) begin
            failures++; $display("FAIL dbg_write_rvalid got=%b exp=0", dbg_rvalid);
        end
    endtask

    task automatic test_lock();
        do_reset();
        next_cycle();
        d_req = 1; d_addr = 16'h0020; i_req = 1; i_addr = 16'h0030; dbg_lock = 1;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            failures++; $display("FAIL lock_entry_gnt got=%b exp=1", d_gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[8] || cpu_hold !== 1'b1 || {d_gnt, i_gnt, mem_en} !== 3'b000) begin
            failures++; $display("FAIL lock_inflight got rv=%b data=%h hold=%b gnt/en=%b exp 1 %h 1 000", d_rvalid, d_rdata, cpu_hold, {d_gnt, i_gnt, mem_en}, ref_mem[8]);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            dbg_req = (k < 3); dbg_we = 0; dbg_addr = 16'h5000 + 16'(4 * k);
            @(negedge clk);
            checks++;
            if (dbg_gnt !== (k < 3) || d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
                failures++; $display("FAIL lock_gnt%0d got dbg=%b d=%b i=%b", k, dbg_gnt, d_gnt, i_gnt);
            end
            if (k > 0) begin
                checks++;
                if (dbg_rvalid !== 1'b1 || dbg_rdata !== ref_mem[14'h1400 + 14'(k - 1)]) begin
                    failures++; $display("FAIL lock_read%0d got rv=%b data=%h exp 1 %h", k, dbg_rvalid, dbg_rdata, ref_mem[14'h1400 + 14'(k - 1)]);
                end
            end
        end
        next_cycle();
        dbg_lock = 0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0 || d_gnt !== 1'b1) begin
            failures++; $display("FAIL unlock got hold=%b d_gnt=%b exp 0 1", cpu_hold, d_gnt);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        next_cycle();
        i_req = 1; i_addr = 16'h0200;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            failures++; $display("FAIL midrst_gnt got=%b exp=1", i_gnt);
        end
        next_cycle();
        drive_idle();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({dbg_rvalid, d_rvalid, i_rvalid} !== 3'b000 || i_rdata !== 32'h0) begin
            failures++; $display("FAIL midrst_rvalid got=%b data=%h exp 000 0", {dbg_rvalid, d_rvalid, i_rvalid}, i_rdata);
        end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({dbg_rvalid, d_rvalid, i_rvalid} !== 3'b000) begin
            failures++; $display("FAIL midrst_after got=%b exp=000", {dbg_rvalid, d_rvalid, i_rvalid});
        end
    endtask

    // Randomized traffic against a reference model of the arbitration rules.
    task automatic test_random();
        int          locked, starve, stalls, owner, win;
        logic [2:0]  exp_g;
        logic [3:0]  exp_we;
        logic [13:0] exp_addr;
        logic [31:0] exp_wd, exp_data;
        do_reset();
        locked = 0; starve = 0; stalls = 0; owner = 0;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) dbg_lock = ~dbg_lock;
            dbg_req = ($urandom_range(0, 3) == 0);
            dbg_we = 1'($urandom); dbg_be = 4'($urandom);
            dbg_addr = 16'($urandom_range(0, 255)); dbg_wdata = $urandom;
            d_req = 1'($urandom); d_we = 1'($urandom); d_be = 4'($urandom);
            d_addr = 16'($urandom_range(0, 255)); d_wdata = $urandom;
            i_req = ($urandom_range(0, 3) != 0);
            i_addr = 16'($urandom_range(0, 255));
            @(negedge clk);
            // 0 none, 1 dbg, 2 data, 3 fetch
            if (rst) win = 0;
            else if (dbg_req) win = 1;
            else if (locked != 0) win = 0;
            else if (starve == MAX_STALL && i_req) win = 3;
            else if (d_req) win = 2;
            else if (i_req) win = 3;
            else win = 0;
            exp_g = {win == 1, win == 2, win == 3};
            checks++;
            if ({dbg_gnt, d_gnt, i_gnt} !== exp_g || mem_en !== (win != 0)) begin
                failures++; $display("FAIL rnd_gnt n=%0d got=%b en=%b exp=%b", n, {dbg_gnt, d_gnt, i_gnt}, mem_en, exp_g);
            end
            exp_we = 0; exp_wd = 0; exp_addr = 0;
            if (win == 1) begin exp_addr = dbg_addr[15:2]; exp_we = dbg_we ? dbg_be : 4'b0; exp_wd = dbg_wdata; end
            if (win == 2) begin exp_addr = d_addr[15:2];   exp_we = d_we ? d_be : 4'b0;     exp_wd = d_wdata;   end
            if (win == 3) begin exp_addr = i_addr[15:2]; end
            if (win != 0) begin
                checks++;
                if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we != 0 && mem_wdata !== exp_wd)) begin
                    failures++; $display("FAIL rnd_mem n=%0d got addr=%h we=%b wd=%h exp %h %b %h", n, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wd);
                end
            end
            exp_data = 0;
            if (!rst && owner != 0 && exp_q.size() > 0) exp_data = exp_q.pop_front();
            checks++;
            if ({dbg_rvalid, d_rvalid, i_rvalid} !== (rst ? 3'b000 : {owner == 1, owner == 2, owner == 3}) ||
                (dbg_rdata | d_rdata | i_rdata) !== exp_data) begin
                failures++; $display("FAIL rnd_resp n=%0d got rv=%b data=%h exp owner=%0d data=%h", n, {dbg_rvalid, d_rvalid, i_rvalid}, dbg_rdata | d_rdata | i_rdata, owner, exp_data);
            end
            checks++;
            if (cpu_hold !== (locked != 0) || fetch_stalls !== CW'(stalls)) begin
                failures++; $display("FAIL rnd_state n=%0d got hold=%b stalls=%0d exp %0d %0d", n, cpu_hold, fetch_stalls, locked, stalls);
            end
            // advance the model
            exp_q.delete();
            if (rst) begin
                locked = 0; starve = 0; stalls = 0; owner = 0;
            end else begin
                if (i_req && win != 3 && stalls < (1 << CW) - 1) stalls++;
                if (!i_req || win == 3) starve = 0;
                else if (locked == 0 && starve < MAX_STALL) starve++;
                locked = dbg_lock ? 1 : 0;
                owner = 0;
                if (win != 0 && exp_we == 0 && !(win == 1 && dbg_we) && !(win == 2 && d_we)) begin
                    owner = win;
                    exp_q.push_back(ref_mem[exp_addr]);
                end
                if (win != 0) ref_write(exp_addr, exp_we, exp_wd);
            end
        end
        next_cycle();
        drive_idle();
    endtask

    // ---------------- main ----------------
    initial begin
        rst = 1;
        drive_idle();
        for (int i = 0; i < NWORDS; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_data_read();
        test_starvation();
        test_dbg_write();
        test_lock();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
